avr_mul_ctrl: RTL

Issue controller that shares the AVR core's single 2-stage multiplier (avr_mul) between the CPU instruction path and a coprocessor port. The controller drives the multiplier operand and mode inputs and routes each result back to its owner. Core requests have absolute priority and never stall. The coprocessor uses a valid/ready handshake with a one-entry result buffer. It sits between the ALU/decoder and avr_mul and fully owns every avr_mul input.

---
 rtl/avr_mul_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/avr_mul_ctrl.sv
// avr_mul_ctrl: issue controller that shares the single 2-stage avr_mul
// between the core instruction path and a coprocessor port.
//
// Ports:
//   ireset, cp2, cp2en            async active-low reset, clock, clock enable
//   core_mul_req, core_*          core issue (never stalls, absolute priority)
//   core_res_vld/res/c/z          core result, valid the cycle after issue
//   cop_req_vld/rdy, cop_*        coprocessor request handshake + operands
//   cop_res_vld/rdy, cop_res/c/z  coprocessor one-entry result buffer
//   mul_rd/rr/muls/mulsu          avr_mul issue-cycle inputs (combinational)
//   mul_fmul                      avr_mul result-cycle shift control (registered)
//   mul_mr/mc/mz                  avr_mul result and flags
module avr_mul_ctrl (
    input  logic        ireset,
    input  logic        cp2,
    input  logic        cp2en,
    input  logic        core_mul_req,
    input  logic        core_fmul,
    input  logic        core_muls,
    input  logic        core_mulsu,
    input  logic [7:0]  core_rd,
    input  logic [7:0]  core_rr,
    output logic        core_res_vld,
    output logic [15:0] core_res,
    output logic        core_c,
    output logic        core_z,
    input  logic        cop_req_vld,
    output logic        cop_req_rdy,
    input  logic        cop_fmul,
    input  logic        cop_muls,
    input  logic        cop_mulsu,
    input  logic [7:0]  cop_rd,
    input  logic [7:0]  cop_rr,
    output logic        cop_res_vld,
    input  logic        cop_res_rdy,
    output logic [15:0] cop_res,
    output logic        cop_c,
    output logic        cop_z,
    output logic        mul_muls,
    output logic        mul_mulsu,
    output logic [7:0]  mul_rd,
    output logic [7:0]  mul_rr,
    output logic        mul_fmul,
    input  logic [15:0] mul_mr,
    input  logic        mul_mc,
    input  logic        mul_mz
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_COP  = 2'd2
    } own_t;

    own_t        s1_own_q, s1_own_d;
    logic        s1_fmul_q, s1_fmul_d;
    logic        cop_res_vld_q, cop_res_vld_d;
    logic [15:0] cop_res_q, cop_res_d;
    logic        cop_c_q, cop_c_d;
    logic        cop_z_q, cop_z_d;

    // Only one coprocessor op may be in flight across stage 1 and the buffer,
    // so a capture and a drain can never land on the same edge.
    assign cop_req_rdy = cp2en & ~core_mul_req & (s1_own_q != OWN_COP) & ~cop_res_vld_q;

    // Operand mux: the coprocessor path is left unqualified by valid; an idle
    // capture is harmless because s1_own records NONE.
    assign mul_rd    = core_mul_req ? core_rd    : cop_rd;
    assign mul_rr    = core_mul_req ? core_rr    : cop_rr;
    assign mul_muls  = core_mul_req ? core_muls  : cop_muls;
    assign mul_mulsu = core_mul_req ? core_mulsu : cop_mulsu;

    // avr_mul applies the FMUL shift after its register, so the mode has to
    // follow the operation into the result cycle.
    assign mul_fmul = s1_fmul_q;

    assign core_res_vld = (s1_own_q == OWN_CORE);
    assign core_res     = mul_mr;
    assign core_c       = mul_mc;
    assign core_z       = mul_mz;

    assign cop_res_vld = cop_res_vld_q;
    assign cop_res     = cop_res_q;
    assign cop_c       = cop_c_q;
    assign cop_z       = cop_z_q;

    always_comb begin
        s1_own_d      = s1_own_q;
        s1_fmul_d     = s1_fmul_q;
        cop_res_vld_d = cop_res_vld_q;
        cop_res_d     = cop_res_q;
        cop_c_d       = cop_c_q;
        cop_z_d       = cop_z_q;
        if (cp2en) begin
            if (core_mul_req) begin
                s1_own_d  = OWN_CORE;
                s1_fmul_d = core_fmul;
            end else if (cop_req_vld && cop_req_rdy) begin
                s1_own_d  = OWN_COP;
                s1_fmul_d = cop_fmul;
            end else begin
                s1_own_d  = OWN_NONE;
                s1_fmul_d = 1'b0;
            end
            if (s1_own_q == OWN_COP) begin
                cop_res_vld_d = 1'b1;
                cop_res_d     = mul_mr;
                cop_c_d       = mul_mc;
                cop_z_d       = mul_mz;
            end else if (cop_res_rdy) begin
                cop_res_vld_d = 1'b0;
            end
        end
    end

    always_ff @(posedge cp2 or negedge ireset) begin
        if (!ireset) begin
            s1_own_q      <= OWN_NONE;
            s1_fmul_q     <= 1'b0;
            cop_res_vld_q <= 1'b0;
            cop_res_q     <= 16'h0000;
            cop_c_q       <= 1'b0;
            cop_z_q       <= 1'b0;
        end else begin
            s1_own_q      <= s1_own_d;
            s1_fmul_q     <= s1_fmul_d;
            cop_res_vld_q <= cop_res_vld_d;
            cop_res_q     <= cop_res_d;
            cop_c_q       <= cop_c_d;
            cop_z_q       <= cop_z_d;
        end
    end

endmodule
